// File: rtl/mshr_refill_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mshr_pkg
//  Description : Shared definitions for the MSHR refill sequencer: state
//                encoding, default widths and line-address formation.
//  Revision    : 1.0 - initial release
// ============================================================================
package mshr_pkg;

    localparam int c_BEAT_W_DEF = 8;
    localparam int c_ID_W_DEF   = 3;
    localparam int c_LA_W       = 64;

    // Refill state encoding, 2 bits wide
    typedef logic [1:0] refill_state_t;

    localparam refill_state_t c_ST_IDLE   = 2'd0;
    localparam refill_state_t c_ST_REFILL = 2'd1;
    localparam refill_state_t c_ST_META   = 2'd2;
    localparam refill_state_t c_ST_DONE   = 2'd3;

    // Replace the low beat_w bits of a line address with a beat index.
    // The function works at the widest supported width; callers cast the
    // result down to their own address width.
    function automatic logic [c_LA_W-1:0] form_line_addr(
        input logic [c_LA_W-1:0] addr,
        input logic [c_LA_W-1:0] idx,
        input int unsigned       beat_w
    );
        logic [c_LA_W-1:0] mask;
        mask = (c_LA_W'(1) << beat_w) - c_LA_W'(1);
        return (addr & ~mask) | (idx & mask);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mshr_refill_seq_beat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : refill_beat_counter
//  Description : Wrap-at-n beat counter. n == 0 encodes 2^BEAT_W beats,
//                because n-1 in BEAT_W-bit arithmetic is all ones.
//  Revision    : 1.0 - initial release
// ============================================================================
module refill_beat_counter #(
    parameter int BEAT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [BEAT_W-1:0] n,
    output logic [BEAT_W-1:0] value,
    output logic              complete
);

    logic [BEAT_W-1:0] r_value;
    logic [BEAT_W-1:0] w_last;
    logic              w_wrap;

    assign w_last   = n - BEAT_W'(1);
    assign w_wrap   = (r_value == w_last);
    assign complete = en & w_wrap;
    assign value    = r_value;

    // Beat counter: clear wins, otherwise advance and wrap on each accepted beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_value <= '0;
        end else if (clr) begin
            r_value <= '0;
        end else if (en) begin
            r_value <= w_wrap ? '0 : r_value + BEAT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/mshr_refill_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mshr_refill_seq
//  Description : MSHR refill sequencer. Takes one refill command, streams
//                the returned beats into the data array, writes the line's
//                metadata and pulses done to the owning MSHR entry.
//  Revision    : 1.0 - initial release
// ============================================================================
module mshr_refill_seq
    import mshr_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int BEAT_W = c_BEAT_W_DEF,
    parameter int ID_W   = c_ID_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [ID_W-1:0]   req_id,
    input  logic [BEAT_W-1:0] req_beats,
    input  logic              mem_resp_valid,
    output logic              mem_resp_ready,
    input  logic [DATA_W-1:0] mem_resp_data,
    output logic              data_wr_en,
    input  logic              data_wr_ready,
    output logic [ADDR_W-1:0] data_wr_addr,
    output logic [DATA_W-1:0] data_wr_data,
    output logic              meta_wr_en,
    input  logic              meta_wr_ready,
    output logic [ADDR_W-1:0] meta_wr_addr,
    output logic              busy,
    output logic [BEAT_W-1:0] beat_idx,
    output logic              done_valid,
    output logic [ID_W-1:0]   done_id
);

    refill_state_t     r_state;
    refill_state_t     w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ID_W-1:0]   r_id;
    logic [BEAT_W-1:0] r_beats;

    logic              w_in_idle;
    logic              w_in_refill;
    logic              w_in_meta;
    logic              w_in_done;
    logic              w_req_acc;
    logic              w_beat_en;
    logic              w_complete;
    logic [BEAT_W-1:0] w_beat_idx;

    assign w_in_idle   = (r_state == c_ST_IDLE);
    assign w_in_refill = (r_state == c_ST_REFILL);
    assign w_in_meta   = (r_state == c_ST_META);
    assign w_in_done   = (r_state == c_ST_DONE);

    assign w_req_acc   = w_in_idle & req_valid;
    // A beat moves only when memory offers it and the data array grants it
    assign w_beat_en   = w_in_refill & mem_resp_valid & data_wr_ready;

    refill_beat_counter #(
        .BEAT_W (BEAT_W)
    ) u_beat_counter (
        .clk      (clk),
        .rst      (rst),
        .clr      (w_req_acc),
        .en       (w_beat_en),
        .n        (r_beats),
        .value    (w_beat_idx),
        .complete (w_complete)
    );

    // Next-state selection for the refill sequence
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:   if (req_valid)     w_state_nxt = c_ST_REFILL;
            c_ST_REFILL: if (w_complete)    w_state_nxt = c_ST_META;
            c_ST_META:   if (meta_wr_ready) w_state_nxt = c_ST_DONE;
            c_ST_DONE:                      w_state_nxt = c_ST_IDLE;
            default:                        w_state_nxt = c_ST_IDLE;
        endcase
    end

    // State register; reset abandons any partial refill without a done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Command latch, loaded only when a new command is taken in IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_id    <= '0;
            r_beats <= '0;
        end else if (w_req_acc) begin
            r_addr  <= req_addr;
            r_id    <= req_id;
            r_beats <= req_beats;
        end
    end

    assign req_ready      = w_in_idle;
    assign busy           = ~w_in_idle;
    assign beat_idx       = w_beat_idx;

    // Beats flow straight through; no beat storage in the sequencer
    assign data_wr_en     = w_in_refill & mem_resp_valid;
    assign mem_resp_ready = w_in_refill & data_wr_ready;
    assign data_wr_data   = w_in_refill ? mem_resp_data : '0;
    assign data_wr_addr   = ADDR_W'(form_line_addr(c_LA_W'(r_addr),
                                                   c_LA_W'(w_beat_idx),
                                                   BEAT_W));

    assign meta_wr_en     = w_in_meta;
    assign meta_wr_addr   = ADDR_W'(form_line_addr(c_LA_W'(r_addr),
                                                   '0, BEAT_W));

    assign done_valid     = w_in_done;
    assign done_id        = r_id;

endmodule
`default_nettype wire

// File: tb/tb_mshr_refill_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mshr_refill_seq
//  Description : Self-checking bench for mshr_refill_seq. Expected data
//                writes are queued when a refill is issued and popped as the
//                data array port accepts them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mshr_refill_seq;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int BEAT_W = 8;
    localparam int ID_W   = 3;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [ID_W-1:0]   req_id;
    logic [BEAT_W-1:0] req_beats;
    logic              mem_resp_valid;
    logic              mem_resp_ready;
    logic [DATA_W-1:0] mem_resp_data;
    logic              data_wr_en;
    logic              data_wr_ready;
    logic [ADDR_W-1:0] data_wr_addr;
    logic [DATA_W-1:0] data_wr_data;
    logic              meta_wr_en;
    logic              meta_wr_ready;
    logic [ADDR_W-1:0] meta_wr_addr;
    logic              busy;
    logic [BEAT_W-1:0] beat_idx;
    logic              done_valid;
    logic [ID_W-1:0]   done_id;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_done = 0;

    logic [ADDR_W-1:0] exp_addr[$];
    logic [DATA_W-1:0] exp_data[$];

    mshr_refill_seq #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .BEAT_W (BEAT_W),
        .ID_W   (ID_W)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .req_id         (req_id),
        .req_beats      (req_beats),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_ready (mem_resp_ready),
        .mem_resp_data  (mem_resp_data),
        .data_wr_en     (data_wr_en),
        .data_wr_ready  (data_wr_ready),
        .data_wr_addr   (data_wr_addr),
        .data_wr_data   (data_wr_data),
        .meta_wr_en     (meta_wr_en),
        .meta_wr_ready  (meta_wr_ready),
        .meta_wr_addr   (meta_wr_addr),
        .busy           (busy),
        .beat_idx       (beat_idx),
        .done_valid     (done_valid),
        .done_id        (done_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] beat_data(input logic [2:0] id, input int i);
        return {16'hBEEF, 13'h0, id, i[31:0] ^ 32'h5A5A_0000};
    endfunction

    // Data-array scoreboard: every granted write must match the next expected beat
    always @(negedge clk) begin
        if (!rst && data_wr_en && data_wr_ready) begin
            if (exp_addr.size() == 0) begin
                check("wr_unexpected", 1, 0);
            end else begin
                check("wr_addr", data_wr_addr, exp_addr.pop_front());
                check("wr_data", data_wr_data, exp_data.pop_front());
            end
        end
        if (done_valid) n_done++;
    end

    task automatic do_refill(input logic [31:0] addr, input logic [2:0] id,
                             input logic [7:0] n, input bit stall_mode,
                             input int meta_stall, input int abort_after,
                             input bit chk_lat);
        int nb, acc, t0, t_last, guard, done0, stall_cnt;
        bit hs;
        nb = (n == 8'd0) ? 256 : int'(n);
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check("req_ready_idle", req_ready, 1);
        for (int i = 0; i < nb; i++) begin
            exp_addr.push_back({addr[31:8], i[7:0]});
            exp_data.push_back(beat_data(id, i));
        end
        meta_wr_ready = (meta_stall == 0);
        req_valid = 1'b1;
        req_addr  = addr;
        req_id    = id;
        req_beats = n;
        @(posedge clk); #1;
        req_valid = 1'b0;
        t0 = cyc;
        done0 = n_done;
        acc = 0; guard = 0; stall_cnt = 0; t_last = t0;
        while (acc < nb && guard < 3000) begin
            guard++;
            mem_resp_valid = stall_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
            mem_resp_data  = beat_data(id, acc);
            data_wr_ready  = !(stall_mode && acc == 2 && stall_cnt < 3);
            @(negedge clk);
            check("beat_idx", beat_idx, acc[7:0]);
            check("no_meta_early", meta_wr_en, 0);
            if (!data_wr_ready) begin
                stall_cnt++;
                check("stall_idx", beat_idx, 2);
                check("stall_mem_ready", mem_resp_ready, 0);
            end
            hs = mem_resp_valid && mem_resp_ready;
            @(posedge clk); #1;
            if (hs) begin
                acc++;
                t_last = cyc;
                if (acc == abort_after) break;
            end
        end
        mem_resp_valid = 1'b0;
        data_wr_ready  = 1'b1;
        if (abort_after > 0) begin
            #3 rst = 1'b1;
            #1;
            check("rst_req_ready", req_ready, 1);
            check("rst_busy", busy, 0);
            check("rst_beat_idx", beat_idx, 0);
            check("rst_data_wr_en", data_wr_en, 0);
            check("rst_meta_wr_en", meta_wr_en, 0);
            check("rst_done_valid", done_valid, 0);
            check("rst_mem_ready", mem_resp_ready, 0);
            @(posedge clk); #1;
            rst = 1'b0;
            exp_addr.delete();
            exp_data.delete();
            repeat (3) begin @(posedge clk); #1; end
            check("abort_no_done", n_done, done0);
            return;
        end
        check("beats_accepted", acc, nb);
        check("meta_en", meta_wr_en, 1);
        check("meta_addr", meta_wr_addr, {addr[31:8], 8'h00});
        check("meta_mem_ready", mem_resp_ready, 0);
        if (chk_lat) check("meta_lat", cyc - t0, nb);
        for (int s = 0; s < meta_stall; s++) begin
            req_valid = 1'b1;
            @(negedge clk);
            check("meta_hold", meta_wr_en, 1);
            check("meta_stall_mem_ready", mem_resp_ready, 0);
            check("busy_req_ready", req_ready, 0);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        meta_wr_ready = 1'b1;
        @(posedge clk); #1;
        check("done_valid", done_valid, 1);
        check("done_id", done_id, id);
        check("done_meta_off", meta_wr_en, 0);
        check("done_after_meta", cyc - t_last, 1 + meta_stall);
        if (chk_lat) check("done_lat", cyc - t0, nb + 1 + meta_stall);
        @(posedge clk); #1;
        check("done_one_cycle", done_valid, 0);
        check("idle_req_ready", req_ready, 1);
        check("idle_beat_idx", beat_idx, 0);
        check("done_count", n_done, done0 + 1);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_addr = '0; req_id = '0; req_beats = '0;
        mem_resp_valid = 1'b0; mem_resp_data = '0;
        data_wr_ready = 1'b1; meta_wr_ready = 1'b1;
        #1;
        check("reset_req_ready", req_ready, 1);
        check("reset_busy", busy, 0);
        check("reset_meta_en", meta_wr_en, 0);
        check("reset_done", done_valid, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        do_refill(32'h1000_0040, 3'd5, 8'd4, 1'b0, 0, 0, 1'b1);
        do_refill(32'h2000_0080, 3'd2, 8'd4, 1'b1, 0, 0, 1'b0);
        do_refill(32'h3000_01FF, 3'd1, 8'd1, 1'b0, 0, 0, 1'b1);
        do_refill(32'h4000_0000, 3'd3, 8'd0, 1'b0, 0, 0, 1'b1);
        do_refill(32'h5000_0000, 3'd6, 8'd4, 1'b0, 0, 2, 1'b0);
        do_refill(32'h6000_0000, 3'd7, 8'd4, 1'b0, 0, 0, 1'b1);
        do_refill(32'h7000_0000, 3'd4, 8'd3, 1'b0, 5, 0, 1'b1);

        check("wr_queue_empty", exp_addr.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/mshr_refill_seq.md
Name: mshr_refill_seq

Overview:
Refill sequencer in the MSHR file of the non-blocking data cache. Accepts one refill command per miss, then streams the N refill beats returned by memory into the data array. Counts beats with a wrapping beat counter and, after the last beat, writes the line's metadata. Pulses done back to the owning MSHR entry. Sits between the memory response channel and the data/meta array write ports, downstream of MSHR allocation.

Parameters:
ADDR_W, 32, line-address width presented to arrays
DATA_W, 64, refill beat width
BEAT_W, 8, beat-counter width; max beats per line 2^BEAT_W
ID_W, 3, MSHR entry id width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  refill command valid
req_ready  out  1  sequencer idle, can accept command
req_addr  in  ADDR_W  line address; low BEAT_W bits ignored
req_id  in  ID_W  requesting MSHR entry
req_beats  in  BEAT_W  beats in line (n); 0 encodes 2^BEAT_W
mem_resp_valid  in  1  refill beat valid
mem_resp_ready  out  1  beat accepted this cycle when both high
mem_resp_data  in  DATA_W  refill beat data
data_wr_en  out  1  data array write request
data_wr_ready  in  1  data array write grant
data_wr_addr  out  ADDR_W  {latched addr[ADDR_W-1:BEAT_W], beat index}
data_wr_data  out  DATA_W  equals mem_resp_data
meta_wr_en  out  1  metadata write request (valid line)
meta_wr_ready  in  1  meta array grant
meta_wr_addr  out  ADDR_W  latched line address, low BEAT_W bits zero
busy  out  1  state != IDLE
beat_idx  out  BEAT_W  current beat counter value
done_valid  out  1  one-cycle completion pulse
done_id  out  ID_W  latched req_id, valid with done_valid

Behaviour:
- States: IDLE, REFILL, META, DONE.
- Reset, asynchronous, at any time, including mid-refill:
  - state IDLE, beat counter 0, latched addr/id 0.
  - All outputs 0 except req_ready=1.
  - A partial refill is abandoned silently; no done pulse.
- IDLE:
  - req_ready=1.
  - On req_valid, latch addr/id/beats, clear counter, go to REFILL next cycle.
- REFILL:
  - data_wr_en = mem_resp_valid.
  - mem_resp_ready = data_wr_ready.
  - A beat is accepted when mem_resp_valid & data_wr_ready. This is en for the counter.
  - Beat stall on either side holds counter and outputs; beats are never dropped or duplicated.
- Counter:
  - wrap = (value == n-1), computed in BEAT_W-bit arithmetic, so n=0 gives n-1 = all ones, i.e. 2^BEAT_W beats.
  - On en: value <= wrap ? 0 : value+1.
  - complete = en & wrap.
- On complete, go to META next cycle; counter returns to 0.
- n=1: first accepted beat completes.
- META:
  - meta_wr_en=1, held until meta_wr_ready; mem_resp_ready=0.
  - Handshake moves to DONE.
- DONE:
  - done_valid=1, done_id=latched id, for exactly one cycle.
  - Then IDLE; req_ready high the following cycle.
- Minimum latency, no stalls: req accept at T, beats at T+1..T+n, META at T+n+1, done_valid at T+n+2, next req accepted at T+n+3.
- req_valid outside IDLE is ignored (req_ready=0).
- mem_resp_valid outside REFILL is not accepted.
- data_wr_data/data_wr_addr are combinational from the current beat and counter; no data storage.
- beat_idx = counter value in every state.

Decomposition:
- Shared package mshr_pkg:
  - refill state enum (IDLE/REFILL/META/DONE, 2-bit)
  - BEAT_W/ID_W default constants
  - line-address formation helper function
- One sub-module: refill_beat_counter, the parametrised wrap-at-n counter.
  - Ports: clk, rst, clr, en, n, value, complete; async reset.
  - complete = en & (value==n-1).

Test Plan:
- req_beats=4, addr=0x1000_0040, id=5, beats back-to-back, grants always high:
  - data writes at 0x1000_0000..0x1000_0003 with matching data
  - meta_wr_addr 0x1000_0000
  - done_valid one cycle at T+6, done_id=5
- req_beats=4, data_wr_ready low on beat 2 for 3 cycles, mem_resp_valid gaps:
  - exactly 4 writes, beat_idx holds 2 during stall
  - complete only on 4th acceptance
- req_beats=1:
  - single write at index 0
  - META next cycle, done at T+3
- req_beats=0, BEAT_W=3:
  - 8 beats written, indices 0..7
  - counter wraps to 0, done after 8th
- rst asserted asynchronously after beat 2 of 4:
  - immediate IDLE, outputs 0, req_ready=1, no done_valid
  - new req then runs cleanly from index 0
- meta_wr_ready low 5 cycles:
  - meta_wr_en held, mem_resp_ready=0
  - done delayed 5 cycles
  - req_valid during busy not accepted
